// File: rtl/sme_pkg.sv
// Shared definitions for the SME string-match engine: ROM geometry,
// pattern limits, terminator byte and the scheduler state encoding.
package sme_pkg;

    localparam int P_AW    = 7;
    localparam int DW      = 8;
    localparam int MAX_LEN = 32;
    localparam int LEN_W   = 6;
    localparam int MAX_PAT = 16;

    localparam logic [DW-1:0] TERM = 8'h00;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] S_ADDR = 3'd1;
    localparam logic [2:0] S_DATA = 3'd2;
    localparam logic [2:0] CHECK  = 3'd3;
    localparam logic [2:0] LAUNCH = 3'd4;
    localparam logic [2:0] RUN    = 3'd5;
    localparam logic [2:0] DONE   = 3'd6;

    // Length counter sticks at its maximum; that value is still above
    // MAX_LEN, so an over-long pattern is always recognised as such.
    function automatic logic [LEN_W-1:0] len_inc(input logic [LEN_W-1:0] l);
        return (l == {LEN_W{1'b1}}) ? l : l + 1'b1;
    endfunction

endpackage

// File: rtl/sme_pattern_sched.sv
// Pattern scheduler: walks the pattern ROM, splits it into TERM-delimited
// patterns and launches the match core once per acceptable pattern.
// The ROM address port is shared with the core while it is running.
module sme_pattern_sched
    import sme_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    output logic [P_AW-1:0]  P_addr,
    input  logic [DW-1:0]    P_data,
    input  logic [P_AW-1:0]  core_p_addr,
    output logic             core_start,
    output logic [P_AW-1:0]  core_base,
    output logic [LEN_W-1:0] core_len,
    output logic [3:0]       pattern_no,
    input  logic             core_done,
    output logic             finish,
    output logic             err_long
);

    logic [2:0]      state;
    logic [P_AW-1:0] ptr;
    logic            eor;
    logic            last_byte;
    logic            last_pattern;
    logic            too_long;

    assign last_byte    = (ptr == {P_AW{1'b1}});
    assign last_pattern = eor || (pattern_no == 4'(MAX_PAT - 1));
    assign too_long     = (core_len > LEN_W'(MAX_LEN));

    // The core owns the ROM address only while it is matching.
    always_comb begin
        P_addr = ptr;
        if (state == RUN) begin
            P_addr = core_p_addr;
        end
    end

    // Scan, check and launch sequencer; all scheduler state lives here.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            ptr        <= '0;
            core_base  <= '0;
            core_len   <= '0;
            pattern_no <= '0;
            eor        <= 1'b0;
            core_start <= 1'b0;
            finish     <= 1'b0;
            err_long   <= 1'b0;
        end else begin
            core_start <= 1'b0;
            case (state)
                IDLE: begin
                    state <= S_ADDR;
                end
                S_ADDR: begin
                    state <= S_DATA;
                end
                S_DATA: begin
                    if (P_data != TERM) begin
                        core_len <= len_inc(core_len);
                        if (last_byte) begin
                            eor   <= 1'b1;
                            state <= CHECK;
                        end else begin
                            ptr   <= ptr + 1'b1;
                            state <= S_ADDR;
                        end
                    end else begin
                        state <= CHECK;
                    end
                end
                CHECK: begin
                    if (core_len == '0) begin
                        state  <= DONE;
                        finish <= 1'b1;
                    end else if (too_long) begin
                        err_long <= 1'b1;
                        if (last_pattern) begin
                            state  <= DONE;
                            finish <= 1'b1;
                        end else begin
                            pattern_no <= pattern_no + 1'b1;
                            ptr        <= ptr + 1'b1;
                            core_base  <= ptr + 1'b1;
                            core_len   <= '0;
                            state      <= S_ADDR;
                        end
                    end else begin
                        core_start <= 1'b1;
                        state      <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    state <= RUN;
                end
                RUN: begin
                    if (core_done) begin
                        if (last_pattern) begin
                            state  <= DONE;
                            finish <= 1'b1;
                        end else begin
                            pattern_no <= pattern_no + 1'b1;
                            ptr        <= ptr + 1'b1;
                            core_base  <= ptr + 1'b1;
                            core_len   <= '0;
                            state      <= S_ADDR;
                        end
                    end
                end
                DONE: begin
                    finish <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sme_pattern_sched.sv
// Self-checking bench for sme_pattern_sched: a ROM model, a responsive
// match-core model, and a reference list of expected launches derived
// directly from the pattern-list rules.
module tb_sme_pattern_sched;
    import sme_pkg::*;

    logic             clk;
    logic             reset;
    logic [P_AW-1:0]  P_addr;
    logic [DW-1:0]    P_data;
    logic [P_AW-1:0]  core_p_addr;
    logic             core_start;
    logic [P_AW-1:0]  core_base;
    logic [LEN_W-1:0] core_len;
    logic [3:0]       pattern_no;
    logic             core_done;
    logic             finish;
    logic             err_long;

    logic [7:0] rom [128];

    int checks;
    int failures;

    int exp_cnt;
    bit exp_err;
    int exp_no   [16];
    int exp_base [16];
    int exp_len  [16];

    int obs_cnt;
    bit in_run;
    bit start_prev;
    bit done_prev;
    int done_cnt;
    bit spur_en;
    bit fixed_addr;

    sme_pattern_sched dut (
        .clk         (clk),
        .reset       (reset),
        .P_addr      (P_addr),
        .P_data      (P_data),
        .core_p_addr (core_p_addr),
        .core_start  (core_start),
        .core_base   (core_base),
        .core_len    (core_len),
        .pattern_no  (pattern_no),
        .core_done   (core_done),
        .finish      (finish),
        .err_long    (err_long)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Synchronous ROM: data appears the cycle after the address.
    always @(posedge clk) begin
        P_data <= rom[P_addr];
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
        end
    endtask

    // Reference: walk the ROM pattern by pattern and list the launches.
    task automatic buildModel();
        int  idx;
        int  no;
        int  len;
        int  start;
        bit  eor;
        bit  stop;
        exp_cnt = 0;
        exp_err = 0;
        idx  = 0;
        no   = 0;
        stop = 0;
        while (!stop) begin
            len   = 0;
            eor   = 0;
            start = idx;
            while (rom[idx] != 8'h00) begin
                len++;
                if (idx == 127) begin
                    eor = 1;
                    break;
                end
                idx++;
            end
            if (len == 0) begin
                stop = 1;
            end else begin
                if (len > MAX_LEN) begin
                    exp_err = 1;
                end else begin
                    exp_no[exp_cnt]   = no;
                    exp_base[exp_cnt] = start;
                    exp_len[exp_cnt]  = len;
                    exp_cnt++;
                end
                if (eor || no == MAX_PAT - 1) begin
                    stop = 1;
                end else begin
                    no++;
                    idx = (idx + 1) % 128;
                end
            end
        end
    endtask

    // Match-core model and launch monitor, evaluated away from the active edge.
    initial begin
        core_done   = 1'b0;
        core_p_addr = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                in_run     = 0;
                start_prev = 0;
                done_prev  = 0;
                done_cnt   = 0;
                obs_cnt    = 0;
                core_done  = 1'b0;
            end else begin
                if (done_prev && in_run) in_run = 0;
                if (start_prev) in_run = 1;
                if (in_run) checkOutput("p_addr_mux", 32'(P_addr), 32'(core_p_addr));
                start_prev = core_start;
                core_done  = 1'b0;
                if (core_start) begin
                    if (obs_cnt < exp_cnt) begin
                        checkOutput("launch_no",   32'(pattern_no), 32'(exp_no[obs_cnt]));
                        checkOutput("launch_base", 32'(core_base),  32'(exp_base[obs_cnt]));
                        checkOutput("launch_len",  32'(core_len),   32'(exp_len[obs_cnt]));
                    end else begin
                        checkOutput("launch_extra", 32'(obs_cnt + 1), 32'(exp_cnt));
                    end
                    obs_cnt++;
                    done_cnt = $urandom_range(1, 4);
                end else if (done_cnt > 0) begin
                    done_cnt--;
                    if (done_cnt == 0) core_done = 1'b1;
                end else if (spur_en && !in_run && ($urandom % 8 == 0)) begin
                    core_done = 1'b1;
                end
                done_prev   = core_done;
                core_p_addr = fixed_addr ? 7'h55 : 7'($urandom);
            end
        end
    end

    task automatic clearRom();
        for (int i = 0; i < 128; i++) rom[i] = 8'h00;
    endtask

    task automatic putStr(inout int pos, input string s, input int reps);
        for (int r = 0; r < reps; r++) begin
            for (int i = 0; i < s.len(); i++) begin
                rom[pos % 128] = s[i];
                pos++;
            end
        end
    endtask

    task automatic putTerm(inout int pos);
        rom[pos % 128] = 8'h00;
        pos++;
    endtask

    // Hold reset for two cycles and check the cleared outputs.
    task automatic applyStimulus();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("rst_start",  32'(core_start), 0);
        checkOutput("rst_finish", 32'(finish),     0);
        checkOutput("rst_no",     32'(pattern_no), 0);
        checkOutput("rst_err",    32'(err_long),   0);
        checkOutput("rst_base",   32'(core_base),  0);
        checkOutput("rst_len",    32'(core_len),   0);
        checkOutput("rst_paddr",  32'(P_addr),     0);
        reset = 1'b0;
    endtask

    task automatic runTest();
        int  n;
        bit  seen;
        buildModel();
        applyStimulus();
        seen = 0;
        for (n = 0; n < 4000 && !seen; n++) begin
            @(negedge clk);
            #1;
            if (finish) seen = 1;
        end
        checkOutput("finish_seen", 32'(seen), 1);
        repeat (6) @(negedge clk);
        #1;
        checkOutput("launch_count", 32'(obs_cnt),    32'(exp_cnt));
        checkOutput("err_long",     32'(err_long),   32'(exp_err));
        checkOutput("finish_hold",  32'(finish),     1);
        checkOutput("start_quiet",  32'(core_start), 0);
    endtask

    initial begin
        int pos;
        int n;
        checks     = 0;
        failures   = 0;
        reset      = 1'b1;
        spur_en    = 0;
        fixed_addr = 0;
        exp_cnt    = 0;
        clearRom();

        // Two short patterns, core address fixed at 7'h55 during RUN.
        clearRom();
        pos = 0;
        putStr(pos, "ab", 1);  putTerm(pos);
        putStr(pos, "cde", 1); putTerm(pos); putTerm(pos);
        fixed_addr = 1;
        runTest();
        fixed_addr = 0;

        // Over-long first pattern is skipped but still numbered.
        clearRom();
        pos = 0;
        putStr(pos, "x", 40); putTerm(pos);
        putStr(pos, "hi", 1); putTerm(pos); putTerm(pos);
        runTest();

        // Seventeen patterns: only sixteen are launched.
        clearRom();
        pos = 0;
        for (int k = 0; k < 17; k++) begin
            putStr(pos, "a", 1); putTerm(pos);
        end
        runTest();

        // Last pattern ends at the top of the ROM without a terminator.
        clearRom();
        pos = 0;
        for (int k = 0; k < 4; k++) begin
            putStr(pos, "q", 24); putTerm(pos);
        end
        putStr(pos, "r", 25); putTerm(pos);
        putStr(pos, "zz", 1);
        runTest();

        // Reset while the core runs the second pattern, then rescan.
        clearRom();
        pos = 0;
        putStr(pos, "ab", 1);  putTerm(pos);
        putStr(pos, "cde", 1); putTerm(pos); putTerm(pos);
        buildModel();
        applyStimulus();
        for (n = 0; n < 500; n++) begin
            @(negedge clk);
            #1;
            if (in_run && obs_cnt == 2) break;
        end
        checkOutput("midrun_reached", 32'(in_run && obs_cnt == 2), 1);
        reset = 1'b1;
        #1;
        checkOutput("async_start",  32'(core_start), 0);
        checkOutput("async_finish", 32'(finish),     0);
        checkOutput("async_no",     32'(pattern_no), 0);
        runTest();

        // Random ROM contents with spurious core_done outside RUN.
        spur_en = 1;
        for (int t = 0; t < 10; t++) begin
            int zdiv;
            zdiv = (t % 2 == 0) ? 4 : 30;
            for (int i = 0; i < 128; i++) begin
                rom[i] = ($urandom % zdiv == 0) ? 8'h00 : 8'($urandom_range(1, 255));
            end
            runTest();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
